// File: rtl/vend_ctrl_param.sv
// Vending-machine controller: price/stock tables, credit accumulation and a
// four-state purchase FSM producing vend, change/refund or selection errors.
module vend_ctrl_param #(
    parameter int NUM_ITEMS   = 16,
    parameter int ITEM_W      = $clog2(NUM_ITEMS),
    parameter int AMT_W       = 16,
    parameter int STOCK_W     = 8,
    parameter int MAX_CREDIT  = 1000,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cfg_we,
    input  logic              cfg_sel,
    input  logic [ITEM_W-1:0] cfg_addr,
    input  logic [AMT_W-1:0]  cfg_wdata,
    output logic [AMT_W-1:0]  cfg_rdata,
    output logic              cfg_err,
    input  logic              coin_valid,
    input  logic [AMT_W-1:0]  coin_val,
    output logic              coin_reject,
    input  logic              sel_valid,
    input  logic [ITEM_W-1:0] sel_item,
    input  logic              cancel,
    output logic [AMT_W-1:0]  credit,
    output logic              vend_valid,
    output logic [ITEM_W-1:0] vend_item,
    output logic              change_valid,
    output logic [AMT_W-1:0]  change_amt,
    output logic              err_valid,
    output logic [1:0]        err_code,
    output logic              busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CREDIT = 2'd1;
    localparam logic [1:0] S_VEND   = 2'd2;
    localparam logic [1:0] S_REFUND = 2'd3;

    localparam int              TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [ITEM_W:0] N_ITEMS  = (ITEM_W + 1)'(NUM_ITEMS);
    localparam logic [AMT_W:0]  MAX_C    = (AMT_W + 1)'(MAX_CREDIT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [1:0]         state;
    logic [AMT_W-1:0]   price [NUM_ITEMS];
    logic [STOCK_W-1:0] stock [NUM_ITEMS];
    logic [TMO_W-1:0]   tmo_cnt;

    logic [AMT_W:0]     coin_sum;
    logic               coin_ok;
    logic [AMT_W-1:0]   eff;
    logic               sel_in_range;
    logic               cfg_in_range;
    logic [ITEM_W-1:0]  sel_idx;
    logic [ITEM_W-1:0]  cfg_idx;
    logic [AMT_W-1:0]   sel_price;
    logic [STOCK_W-1:0] sel_stock;
    logic [1:0]         sel_err;
    logic               tmo_hit;
    logic               refund_go;
    logic               vend_go;

    // The sum is one bit wider than credit so an oversized coin can never wrap
    // into an apparently small total.
    always_comb begin
        coin_sum     = {1'b0, credit} + {1'b0, coin_val};
        coin_ok      = coin_valid && (state == S_IDLE || state == S_CREDIT) && (coin_sum <= MAX_C);
        eff          = coin_ok ? coin_sum[AMT_W-1:0] : credit;
        sel_in_range = {1'b0, sel_item} < N_ITEMS;
        cfg_in_range = {1'b0, cfg_addr} < N_ITEMS;
        sel_idx      = sel_in_range ? sel_item : '0;
        cfg_idx      = cfg_in_range ? cfg_addr : '0;
        sel_price    = price[sel_idx];
        sel_stock    = stock[sel_idx];
        if (!sel_in_range)
            sel_err = 2'd1;
        else if (sel_stock == '0)
            sel_err = 2'd2;
        else if (eff < sel_price)
            sel_err = 2'd3;
        else
            sel_err = 2'd0;
        tmo_hit   = (state == S_CREDIT) && !cancel && !sel_valid && !coin_ok && (tmo_cnt == TMO_LAST);
        refund_go = (state == S_CREDIT) && (cancel || tmo_hit);
        vend_go   = (state == S_CREDIT) && !cancel && sel_valid && (sel_err == 2'd0);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                price[i] <= '0;
                stock[i] <= '0;
            end
            cfg_rdata <= '0;
        end else begin
            if (cfg_we && state == S_IDLE && cfg_in_range) begin
                if (cfg_sel)
                    stock[cfg_idx] <= cfg_wdata[STOCK_W-1:0];
                else
                    price[cfg_idx] <= cfg_wdata;
            end
            // Writes (IDLE only) and decrements (CREDIT only) never coincide.
            if (vend_go)
                stock[sel_idx] <= sel_stock - STOCK_W'(1);
            if (!cfg_in_range)
                cfg_rdata <= '0;
            else if (cfg_sel)
                cfg_rdata <= AMT_W'(stock[cfg_idx]);
            else
                cfg_rdata <= price[cfg_idx];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= S_IDLE;
            credit       <= '0;
            tmo_cnt      <= '0;
            cfg_err      <= 1'b0;
            coin_reject  <= 1'b0;
            vend_valid   <= 1'b0;
            vend_item    <= '0;
            change_valid <= 1'b0;
            change_amt   <= '0;
            err_valid    <= 1'b0;
            err_code     <= '0;
        end else begin
            cfg_err      <= cfg_we && (state != S_IDLE || !cfg_in_range);
            coin_reject  <= coin_valid && !coin_ok;
            vend_valid   <= 1'b0;
            change_valid <= 1'b0;
            err_valid    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (coin_ok) begin
                        credit  <= eff;
                        tmo_cnt <= '0;
                        if (coin_val != '0)
                            state <= S_CREDIT;
                    end
                end
                S_CREDIT: begin
                    if (refund_go) begin
                        state        <= S_REFUND;
                        change_valid <= 1'b1;
                        change_amt   <= eff;
                        credit       <= '0;
                        tmo_cnt      <= '0;
                    end else if (vend_go) begin
                        state        <= S_VEND;
                        vend_valid   <= 1'b1;
                        vend_item    <= sel_item;
                        change_valid <= 1'b1;
                        change_amt   <= eff - sel_price;
                        credit       <= '0;
                        tmo_cnt      <= '0;
                    end else if (sel_valid) begin
                        err_valid <= 1'b1;
                        err_code  <= sel_err;
                        credit    <= eff;
                        if (coin_ok)
                            tmo_cnt <= '0;
                    end else if (coin_ok) begin
                        credit  <= eff;
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Scoreboard bench for vend_ctrl_param: a negedge monitor records every output
// pulse, each scenario task queues what it expects and compares at its end.
module tb_vend_ctrl_param;

    localparam int NI = 12;
    localparam int IW = $clog2(NI);
    localparam int AW = 16;
    localparam int SW = 8;
    localparam int MC = 1000;
    localparam int TO = 64;

    logic          clk;
    logic          rstn;
    logic          cfg_we;
    logic          cfg_sel;
    logic [IW-1:0] cfg_addr;
    logic [AW-1:0] cfg_wdata;
    logic [AW-1:0] cfg_rdata;
    logic          cfg_err;
    logic          coin_valid;
    logic [AW-1:0] coin_val;
    logic          coin_reject;
    logic          sel_valid;
    logic [IW-1:0] sel_item;
    logic          cancel;
    logic [AW-1:0] credit;
    logic          vend_valid;
    logic [IW-1:0] vend_item;
    logic          change_valid;
    logic [AW-1:0] change_amt;
    logic          err_valid;
    logic [1:0]    err_code;
    logic          busy;

    typedef struct packed {
        logic [4:0]    f;     // {vend, change, err, coin_reject, cfg_err}
        logic [IW-1:0] item;
        logic [AW-1:0] amt;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  checks   = 0;
    int  failures = 0;

    vend_ctrl_param #(
        .NUM_ITEMS(NI), .AMT_W(AW), .STOCK_W(SW), .MAX_CREDIT(MC), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rstn(rstn),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_rdata(cfg_rdata), .cfg_err(cfg_err),
        .coin_valid(coin_valid), .coin_val(coin_val), .coin_reject(coin_reject),
        .sel_valid(sel_valid), .sel_item(sel_item), .cancel(cancel),
        .credit(credit), .vend_valid(vend_valid), .vend_item(vend_item),
        .change_valid(change_valid), .change_amt(change_amt),
        .err_valid(err_valid), .err_code(err_code), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (vend_valid || change_valid || err_valid || coin_reject || cfg_err) begin
            ev_t o;
            o.f    = {vend_valid, change_valid, err_valid, coin_reject, cfg_err};
            o.item = vend_valid ? vend_item : '0;
            o.amt  = change_valid ? change_amt : (err_valid ? AW'(err_code) : '0);
            obs_q.push_back(o);
        end
    end

    function automatic ev_t mk(input logic [4:0] f, input int item, input int amt);
        ev_t e;
        e.f    = f;
        e.item = IW'(item);
        e.amt  = AW'(amt);
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic s, input int addr, input int data);
        cfg_we = 1'b1; cfg_sel = s; cfg_addr = IW'(addr); cfg_wdata = AW'(data);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic cfg_read(input logic s, input int addr);
        cfg_sel = s; cfg_addr = IW'(addr);
        step();
    endtask

    task automatic coin(input int v);
        coin_valid = 1'b1; coin_val = AW'(v);
        step();
        coin_valid = 1'b0;
    endtask

    task automatic sel(input int item);
        sel_valid = 1'b1; sel_item = IW'(item);
        step();
        sel_valid = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
    endtask

    task automatic settle();
        for (int i = 0; i < 3; i++) step();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        cfg_we = 0; cfg_sel = 0; cfg_addr = '0; cfg_wdata = '0;
        coin_valid = 0; coin_val = '0; sel_valid = 0; sel_item = '0; cancel = 0;
        step(); step(); step();
        checks++;
        if ({vend_valid, change_valid, err_valid, coin_reject, cfg_err, busy} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b want=000000",
                     {vend_valid, change_valid, err_valid, coin_reject, cfg_err, busy});
        end
        checks++;
        if ({credit, cfg_rdata, change_amt, vend_item, err_code} !== '0) begin
            failures++;
            $display("FAIL reset_data credit=%0d rdata=%0d chg=%0d item=%0d code=%0d want all 0",
                     credit, cfg_rdata, change_amt, vend_item, err_code);
        end
        rstn = 1'b1;
        step();
    endtask

    task automatic test_config();
        cfg_write(0, 3, 75);
        cfg_write(1, 3, 2);
        cfg_write(0, 7, 30);
        cfg_write(1, 7, 5);
        cfg_write(0, 5, 0);
        cfg_write(1, 5, 1);
        exp_q.push_back(mk(5'b00001, 0, 0));
        cfg_write(0, 12, 55);
        cfg_read(0, 3);
        checks++;
        if (cfg_rdata !== 16'd75) begin failures++; $display("FAIL cfg_price3 got=%0d want=75", cfg_rdata); end
        cfg_read(1, 3);
        checks++;
        if (cfg_rdata !== 16'd2) begin failures++; $display("FAIL cfg_stock3 got=%0d want=2", cfg_rdata); end
        cfg_read(0, 12);
        checks++;
        if (cfg_rdata !== 16'd0) begin failures++; $display("FAIL cfg_oor_read got=%0d want=0", cfg_rdata); end
        cfg_read(1, 7);
        checks++;
        if (cfg_rdata !== 16'd5) begin failures++; $display("FAIL cfg_stock7 got=%0d want=5", cfg_rdata); end
        settle();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL config_events count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ev_t e = exp_q.pop_front(); ev_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL config_event got=%h want=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_vend();
        coin(50);
        coin(50);
        checks++;
        if (credit !== 16'd100 || busy !== 1'b1) begin
            failures++; $display("FAIL vend_credit got=%0d busy=%b want=100 busy=1", credit, busy);
        end
        exp_q.push_back(mk(5'b11000, 3, 25));
        sel(3);
        checks++;
        if (vend_valid !== 1'b1 || vend_item !== 4'd3 || change_amt !== 16'd25) begin
            failures++;
            $display("FAIL vend_latency got vv=%b item=%0d chg=%0d want vv=1 item=3 chg=25",
                     vend_valid, vend_item, change_amt);
        end
        step();
        checks++;
        if (credit !== 16'd0 || busy !== 1'b0) begin
            failures++; $display("FAIL vend_after got credit=%0d busy=%b want 0 0", credit, busy);
        end
        cfg_read(1, 3);
        checks++;
        if (cfg_rdata !== 16'd1) begin failures++; $display("FAIL vend_stock3 got=%0d want=1", cfg_rdata); end
        settle();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL vend_events count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ev_t e = exp_q.pop_front(); ev_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL vend_event got=%h want=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_sold_out();
        coin(100);
        exp_q.push_back(mk(5'b11000, 3, 25));
        sel(3);
        step();
        coin(100);
        exp_q.push_back(mk(5'b00100, 0, 2));
        sel(3);
        checks++;
        if (credit !== 16'd100) begin failures++; $display("FAIL soldout_credit got=%0d want=100", credit); end
        exp_q.push_back(mk(5'b01000, 0, 100));
        do_cancel();
        step();
        cfg_read(1, 3);
        checks++;
        if (cfg_rdata !== 16'd0 || credit !== 16'd0) begin
            failures++; $display("FAIL soldout_stock got stock=%0d credit=%0d want 0 0", cfg_rdata, credit);
        end
        settle();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL soldout_events count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ev_t e = exp_q.pop_front(); ev_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL soldout_event got=%h want=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_errors();
        cfg_write(1, 3, 1);
        coin(20);
        exp_q.push_back(mk(5'b00100, 0, 3));
        sel(3);
        checks++;
        if (credit !== 16'd20 || busy !== 1'b1) begin
            failures++; $display("FAIL err3_credit got=%0d busy=%b want=20 busy=1", credit, busy);
        end
        exp_q.push_back(mk(5'b00100, 0, 1));
        sel(NI);
        exp_q.push_back(mk(5'b11000, 5, 20));
        sel(5);
        step();
        checks++;
        if (credit !== 16'd0) begin failures++; $display("FAIL free_item_credit got=%0d want=0", credit); end
        settle();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL errors_events count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ev_t e = exp_q.pop_front(); ev_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL errors_event got=%h want=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_max_credit();
        coin(600);
        exp_q.push_back(mk(5'b00010, 0, 0));
        coin(500);
        checks++;
        if (credit !== 16'd600) begin failures++; $display("FAIL maxc_reject_credit got=%0d want=600", credit); end
        exp_q.push_back(mk(5'b01000, 0, 600));
        sel_valid = 1'b1; sel_item = 4'd7; cancel = 1'b1;
        step();
        sel_valid = 1'b0; cancel = 1'b0;
        step();
        coin(MC);
        checks++;
        if (credit !== 16'(MC)) begin failures++; $display("FAIL maxc_boundary got=%0d want=%0d", credit, MC); end
        exp_q.push_back(mk(5'b00010, 0, 0));
        coin(1);
        exp_q.push_back(mk(5'b01000, 0, MC));
        do_cancel();
        step();
        cfg_read(1, 7);
        checks++;
        if (cfg_rdata !== 16'd5) begin failures++; $display("FAIL maxc_stock7 got=%0d want=5", cfg_rdata); end
        settle();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL maxc_events count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ev_t e = exp_q.pop_front(); ev_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL maxc_event got=%h want=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back();
        coin(0);
        checks++;
        if (busy !== 1'b0 || credit !== 16'd0) begin
            failures++; $display("FAIL zero_coin got busy=%b credit=%0d want 0 0", busy, credit);
        end
        coin(30);
        exp_q.push_back(mk(5'b11000, 7, 0));
        sel(7);
        exp_q.push_back(mk(5'b00010, 0, 0));
        coin(10);
        checks++;
        if (credit !== 16'd0 || busy !== 1'b0) begin
            failures++; $display("FAIL b2b_vend_coin got credit=%0d busy=%b want 0 0", credit, busy);
        end
        coin(30);
        exp_q.push_back(mk(5'b11000, 7, 0));
        sel(7);
        step();
        cfg_read(1, 7);
        checks++;
        if (cfg_rdata !== 16'd3) begin failures++; $display("FAIL b2b_stock7 got=%0d want=3", cfg_rdata); end
        settle();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL b2b_events count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ev_t e = exp_q.pop_front(); ev_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL b2b_event got=%h want=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_timeout();
        int n_hit;
        n_hit = -1;
        exp_q.push_back(mk(5'b01000, 0, 10));
        coin(10);
        for (int n = 1; n <= TO + 4; n++) begin
            step();
            if (change_valid === 1'b1) begin
                n_hit = n;
                break;
            end
        end
        checks++;
        if (n_hit != TO) begin failures++; $display("FAIL timeout_cycles got=%0d want=%0d", n_hit, TO); end
        step();
        coin(10);
        exp_q.push_back(mk(5'b00001, 0, 0));
        cfg_write(0, 3, 999);
        exp_q.push_back(mk(5'b01000, 0, 10));
        do_cancel();
        step();
        cfg_read(0, 3);
        checks++;
        if (cfg_rdata !== 16'd75) begin failures++; $display("FAIL credit_cfg_drop got=%0d want=75", cfg_rdata); end
        settle();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL timeout_events count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ev_t e = exp_q.pop_front(); ev_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL timeout_event got=%h want=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid();
        coin(40);
        checks++;
        if (busy !== 1'b1 || credit !== 16'd40) begin
            failures++; $display("FAIL midrst_pre got busy=%b credit=%0d want 1 40", busy, credit);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if ({vend_valid, change_valid, err_valid, coin_reject, cfg_err, busy} !== 6'b0 || credit !== 16'd0) begin
            failures++;
            $display("FAIL midrst_outputs got flags=%b credit=%0d want 0 0",
                     {vend_valid, change_valid, err_valid, coin_reject, cfg_err, busy}, credit);
        end
        step(); step();
        rstn = 1'b1;
        step();
        cfg_read(0, 3);
        checks++;
        if (cfg_rdata !== 16'd0) begin failures++; $display("FAIL midrst_table got=%0d want=0", cfg_rdata); end
        settle();
        checks++;
        if (obs_q.size() != 0) begin
            failures++; $display("FAIL midrst_events count got=%0d want=0", obs_q.size());
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_config();
        test_vend();
        test_sold_out();
        test_errors();
        test_max_credit();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
